decode_ctrl_stage: RTL and testbench



---
 rtl/decode_pkg.sv | 97 +++++++++
 rtl/md_sequencer.sv | 55 +++++
 rtl/decode_ctrl_stage.sv | 210 +++++++++++++++++++++
 tb/tb_decode_ctrl_stage.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg
//   Shared definitions for the RV32IM decode control stage: opcode and
//   funct7 constants, 5-bit ALU operation codes, ResultSrc/ImmSrc encodings,
//   the mul/div sequencer state encoding and the packed E-stage control
//   bundle ctrl_t. The all-zero ctrl_t value is a bubble.
package decode_pkg;

  // Major opcodes (InstrD[6:0])
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // funct7 classes
  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  // ALU codes: {0, legacy 4-bit}; M ops are {2'b10, funct3}
  localparam logic [4:0] ALU_ADD  = 5'b00000;
  localparam logic [4:0] ALU_SUB  = 5'b00001;
  localparam logic [4:0] ALU_AND  = 5'b00010;
  localparam logic [4:0] ALU_OR   = 5'b00011;
  localparam logic [4:0] ALU_XOR  = 5'b00100;
  localparam logic [4:0] ALU_SLT  = 5'b00101;
  localparam logic [4:0] ALU_SLTU = 5'b00110;
  localparam logic [4:0] ALU_SLL  = 5'b00111;
  localparam logic [4:0] ALU_SRL  = 5'b01000;
  localparam logic [4:0] ALU_BGE  = 5'b01001;
  localparam logic [4:0] ALU_BGEU = 5'b01010;
  localparam logic [4:0] ALU_SRA  = 5'b01011;
  localparam logic [4:0] ALU_BNE  = 5'b01100;
  localparam logic [4:0] ALU_LUI  = 5'b01111;
  localparam logic [1:0] ALU_MD_PREFIX = 2'b10;

  typedef enum logic [1:0] {
    RES_ALU   = 2'b00,
    RES_MEM   = 2'b01,
    RES_PC4   = 2'b10,
    RES_PCIMM = 2'b11
  } result_src_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_e;

  // Sequencer states kept as plain constants so older code can compare
  // against them directly.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  typedef enum logic [0:0] {
    MD_IDLE = ST_IDLE,
    MD_BUSY = ST_BUSY
  } md_state_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic        jalr;
    result_src_e result_src;
    logic [4:0]  alu_ctrl;
    logic [2:0]  addr_ctrl;
    logic        muldiv;
    logic        illegal;
  } ctrl_t;

  // ALU op for register/immediate arithmetic selected by funct3 alone
  // (funct7 variants are handled by the caller).
  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    logic [4:0] op;
    case (f3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/md_sequencer.sv
// md_sequencer
//   Holds a multi-cycle mul/div in Execute. On start (an M-op entering E)
//   the down-counter loads n_cycles-1; busy stays high until it runs out, so
//   the op occupies E for exactly n_cycles cycles with busy high for all but
//   the last one.
// Ports:
//   clk, rst   clock, synchronous active-high reset (aborts any sequence)
//   start      M-op is being captured into E this edge
//   n_cycles   Execute occupancy of that op (>=1)
//   busy       high while the sequence still has cycles left after this one
module md_sequencer
  import decode_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] n_cycles,
  output logic       busy
);

  md_state_e  state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      MD_IDLE: begin
        if (start) begin
          cnt_next = n_cycles - 8'd1;
          // single-cycle ops complete without ever raising busy
          if (n_cycles > 8'd1) state_next = MD_BUSY;
        end
      end
      MD_BUSY: begin
        cnt_next = cnt_reg - 8'd1;
        if (cnt_reg == 8'd1) state_next = MD_IDLE;
      end
      default: state_next = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= MD_IDLE;
      cnt_reg   <= 8'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  assign busy = (state_reg == MD_BUSY);

endmodule

// File: rtl/decode_ctrl_stage.sv
// decode_ctrl_stage
//   RV32I(+M) decode control. ImmSrcD is combinational from InstrD; all other
//   controls are registered into the D->E register. Illegal encodings enter
//   E as a bubble with IllegalE set. While a multi-cycle mul/div is running
//   the E register holds (FlushE ignored) and MdBusy stalls F/D.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   InstrD               instruction in Decode
//   FlushE               flush E to a bubble (ignored while MdBusy)
//   ImmSrcD              immediate format select for the D-stage extender
//   RegWriteE..JALRInstrE, ResultSrcE, ALUControlE, AddressingControlE
//                        registered E-stage controls
//   MulDivE              E holds an M-op
//   MdLastE              final E cycle of that M-op (result valid)
//   IllegalE             E holds a bubbled illegal instruction
//   MdBusy               stall request to the hazard unit
module decode_ctrl_stage
  import decode_pkg::*;
#(
  parameter int ALU_CTRL_W = 5,
  parameter int EN_M       = 1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 33
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           InstrD,
  input  logic                  FlushE,
  output logic [2:0]            ImmSrcD,
  output logic                  RegWriteE,
  output logic                  MemWriteE,
  output logic                  JumpE,
  output logic                  BranchE,
  output logic                  ALUSrcE,
  output logic                  JALRInstrE,
  output logic [1:0]            ResultSrcE,
  output logic [ALU_CTRL_W-1:0] ALUControlE,
  output logic [2:0]            AddressingControlE,
  output logic                  MulDivE,
  output logic                  MdLastE,
  output logic                  IllegalE,
  output logic                  MdBusy
);

  localparam logic [7:0] MUL_N = 8'(MUL_CYCLES);
  localparam logic [7:0] DIV_N = 8'(DIV_CYCLES);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       unused_fields;

  assign opcode = InstrD[6:0];
  assign funct3 = InstrD[14:12];
  assign funct7 = InstrD[31:25];
  // register and immediate fields are consumed by the datapath, not here
  assign unused_fields = ^{InstrD[24:15], InstrD[11:7]};

  ctrl_t    dec;
  ctrl_t    ctrl_d;
  imm_src_e imm_src;
  logic     illegal;

  always_comb begin
    dec     = '0;
    imm_src = IMM_I;
    illegal = 1'b0;
    case (opcode)
      OP_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = RES_MEM;
        dec.addr_ctrl  = funct3;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111) illegal = 1'b1;
      end
      OP_STORE: begin
        imm_src       = IMM_S;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.addr_ctrl = funct3;
        if (funct3 > 3'b010) illegal = 1'b1;
      end
      OP_R: begin
        dec.reg_write = 1'b1;
        case (funct7)
          F7_BASE: dec.alu_ctrl = base_alu(funct3);
          F7_ALT: begin
            if (funct3 == 3'b000)      dec.alu_ctrl = ALU_SUB;
            else if (funct3 == 3'b101) dec.alu_ctrl = ALU_SRA;
            else                       illegal = 1'b1;
          end
          F7_MULDIV: begin
            if (EN_M != 0) begin
              dec.alu_ctrl = {ALU_MD_PREFIX, funct3};
              dec.muldiv   = 1'b1;
            end else begin
              illegal = 1'b1;
            end
          end
          default: illegal = 1'b1;
        endcase
      end
      OP_IMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        // funct7 is only an opcode field for the shifts; otherwise it is
        // part of the immediate and must not be checked
        if (funct3 == 3'b001) begin
          dec.alu_ctrl = ALU_SLL;
          if (funct7 != F7_BASE) illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          if (funct7 == F7_BASE)     dec.alu_ctrl = ALU_SRL;
          else if (funct7 == F7_ALT) dec.alu_ctrl = ALU_SRA;
          else                       illegal = 1'b1;
        end else begin
          dec.alu_ctrl = base_alu(funct3);
        end
      end
      OP_BRANCH: begin
        imm_src    = IMM_B;
        dec.branch = 1'b1;
        case (funct3)
          3'b000:  dec.alu_ctrl = ALU_SUB;   // beq: zero flag of a-b
          3'b001:  dec.alu_ctrl = ALU_BNE;
          3'b100:  dec.alu_ctrl = ALU_SLT;   // blt
          3'b101:  dec.alu_ctrl = ALU_BGE;
          3'b110:  dec.alu_ctrl = ALU_SLTU;  // bltu
          3'b111:  dec.alu_ctrl = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        imm_src        = IMM_J;
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = RES_PC4;
      end
      OP_JALR: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.jump       = 1'b1;
        dec.jalr       = 1'b1;
        dec.result_src = RES_PC4;
      end
      OP_LUI: begin
        imm_src       = IMM_U;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = ALU_LUI;
      end
      OP_AUIPC: begin
        imm_src        = IMM_U;
        dec.reg_write  = 1'b1;
        dec.result_src = RES_PCIMM;
      end
      default: illegal = 1'b1;
    endcase

    ctrl_d = dec;
    if (illegal) begin
      ctrl_d         = '0;
      ctrl_d.illegal = 1'b1;
    end
  end

  assign ImmSrcD = imm_src;

  // Sequencer: an M-op starts only when it actually lands in E.
  logic       md_start;
  logic [7:0] md_n;
  logic       md_busy;

  assign md_start = ctrl_d.muldiv & ~md_busy & ~FlushE;
  assign md_n     = funct3[2] ? DIV_N : MUL_N;

  md_sequencer u_md_sequencer (
    .clk      (clk),
    .rst      (rst),
    .start    (md_start),
    .n_cycles (md_n),
    .busy     (md_busy)
  );

  ctrl_t e_reg;

  // Busy hold takes priority over flush so the running op is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_reg <= '0;
    end else if (!md_busy) begin
      if (FlushE) e_reg <= '0;
      else        e_reg <= ctrl_d;
    end
  end

  assign RegWriteE          = e_reg.reg_write;
  assign MemWriteE          = e_reg.mem_write;
  assign JumpE              = e_reg.jump;
  assign BranchE            = e_reg.branch;
  assign ALUSrcE            = e_reg.alu_src;
  assign JALRInstrE         = e_reg.jalr;
  assign ResultSrcE         = e_reg.result_src;
  assign ALUControlE        = ALU_CTRL_W'(e_reg.alu_ctrl);
  assign AddressingControlE = e_reg.addr_ctrl;
  assign MulDivE            = e_reg.muldiv;
  assign IllegalE           = e_reg.illegal;
  assign MdBusy             = md_busy;
  assign MdLastE            = e_reg.muldiv & ~md_busy;

endmodule

// File: tb/tb_decode_ctrl_stage.sv
// tb_decode_ctrl_stage
//   Three instances share stimulus: [0] defaults (EN_M=1, mul 2, div 33),
//   [1] EN_M=0, [2] single-cycle mul/div. Table-driven decode vectors on
//   instance 0, then hand sequences for div, mul->divu, flush and reset.
module tb_decode_ctrl_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        FlushE;
  logic [31:0] InstrD;

  always #5 clk = ~clk;

  logic [2:0] imm  [3];
  logic       rw   [3];
  logic       mw   [3];
  logic       jmp  [3];
  logic       br   [3];
  logic       asrc [3];
  logic       jalr [3];
  logic [1:0] rsrc [3];
  logic [4:0] alu  [3];
  logic [2:0] addr [3];
  logic       md   [3];
  logic       last [3];
  logic       ill  [3];
  logic       busy [3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    decode_ctrl_stage #(
      .ALU_CTRL_W (5),
      .EN_M       ((gi == 1) ? 0 : 1),
      .MUL_CYCLES ((gi == 2) ? 1 : 2),
      .DIV_CYCLES ((gi == 2) ? 1 : 33)
    ) dut (
      .clk                (clk),
      .rst                (rst),
      .InstrD             (InstrD),
      .FlushE             (FlushE),
      .ImmSrcD            (imm[gi]),
      .RegWriteE          (rw[gi]),
      .MemWriteE          (mw[gi]),
      .JumpE              (jmp[gi]),
      .BranchE            (br[gi]),
      .ALUSrcE            (asrc[gi]),
      .JALRInstrE         (jalr[gi]),
      .ResultSrcE         (rsrc[gi]),
      .ALUControlE        (alu[gi]),
      .AddressingControlE (addr[gi]),
      .MulDivE            (md[gi]),
      .MdLastE            (last[gi]),
      .IllegalE           (ill[gi]),
      .MdBusy             (busy[gi])
    );
  end

  int checks = 0;
  int errors = 0;

  // {ImmSrcD, RegWrite, MemWrite, Jump, Branch, ALUSrc, JALR, ResultSrc,
  //  ALUControl, Addressing, MulDiv, Illegal}
  function automatic logic [20:0] obs(input int d);
    return {imm[d], rw[d], mw[d], jmp[d], br[d], asrc[d], jalr[d],
            rsrc[d], alu[d], addr[d], md[d], ill[d]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [31:0] instr;
    logic [20:0] exp;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  localparam logic [31:0] I_ADD   = 32'h002081B3;
  localparam logic [31:0] I_DIV   = 32'h0220C1B3;
  localparam logic [31:0] I_MUL   = 32'h022081B3;
  localparam logic [31:0] I_DIVU  = 32'h0220D1B3;
  localparam logic [31:0] I_AUIPC = 32'h00000197;

  localparam logic [20:0] EXP_DIV  = {3'b000, 6'b100000, 2'b00, 5'b10100, 3'b000, 2'b10};
  localparam logic [20:0] EXP_MUL  = {3'b000, 6'b100000, 2'b00, 5'b10000, 3'b000, 2'b10};
  localparam logic [20:0] EXP_DIVU = {3'b000, 6'b100000, 2'b00, 5'b10101, 3'b000, 2'b10};
  localparam logic [20:0] EXP_ILL  = 21'd1;

  initial begin
    vecs[0]  = '{I_ADD,        {3'b000, 6'b100000, 2'b00, 5'b00000, 3'b000, 2'b00}};
    vecs[1]  = '{32'h402081B3, {3'b000, 6'b100000, 2'b00, 5'b00001, 3'b000, 2'b00}}; // sub
    vecs[2]  = '{32'h422081B3, {3'b000, EXP_ILL[17:0]}};                            // sub f7=0100001
    vecs[3]  = '{32'h4020D1B3, {3'b000, 6'b100000, 2'b00, 5'b01011, 3'b000, 2'b00}}; // sra
    vecs[4]  = '{32'h4020F1B3, {3'b000, EXP_ILL[17:0]}};                            // and f7=0100000
    vecs[5]  = '{32'h00500093, {3'b000, 6'b100010, 2'b00, 5'b00000, 3'b000, 2'b00}}; // addi
    vecs[6]  = '{32'hFFF12093, {3'b000, 6'b100010, 2'b00, 5'b00101, 3'b000, 2'b00}}; // slti
    vecs[7]  = '{32'h4030D093, {3'b000, 6'b100010, 2'b00, 5'b01011, 3'b000, 2'b00}}; // srai
    vecs[8]  = '{32'h00812283, {3'b000, 6'b100010, 2'b01, 5'b00000, 3'b010, 2'b00}}; // lw
    vecs[9]  = '{32'h00813283, {3'b000, EXP_ILL[17:0]}};                            // load f3=011
    vecs[10] = '{32'h00512423, {3'b001, 6'b010010, 2'b00, 5'b00000, 3'b010, 2'b00}}; // sw
    vecs[11] = '{32'h00513423, {3'b001, EXP_ILL[17:0]}};                            // store f3=011
    vecs[12] = '{32'h00208063, {3'b010, 6'b000100, 2'b00, 5'b00001, 3'b000, 2'b00}}; // beq
    vecs[13] = '{32'h00209063, {3'b010, 6'b000100, 2'b00, 5'b01100, 3'b000, 2'b00}}; // bne
    vecs[14] = '{32'h0020F063, {3'b010, 6'b000100, 2'b00, 5'b01010, 3'b000, 2'b00}}; // bgeu
    vecs[15] = '{32'h0020A063, {3'b010, EXP_ILL[17:0]}};                            // branch f3=010
    vecs[16] = '{32'h000000EF, {3'b011, 6'b101000, 2'b10, 5'b00000, 3'b000, 2'b00}}; // jal
    vecs[17] = '{32'h000100E7, {3'b000, 6'b101011, 2'b10, 5'b00000, 3'b000, 2'b00}}; // jalr
    vecs[18] = '{32'h123450B7, {3'b100, 6'b100010, 2'b00, 5'b01111, 3'b000, 2'b00}}; // lui
    vecs[19] = '{I_AUIPC,      {3'b100, 6'b100000, 2'b11, 5'b00000, 3'b000, 2'b00}}; // auipc
    vecs[20] = '{32'h0000007F, {3'b000, EXP_ILL[17:0]}};                            // bad opcode
    vecs[21] = '{32'h40109093, {3'b000, EXP_ILL[17:0]}};                            // slli f7=0100000
    vecs[22] = '{32'h00113093, {3'b000, 6'b100010, 2'b00, 5'b00110, 3'b000, 2'b00}}; // sltiu

    // reset state
    rst = 1'b1; FlushE = 1'b0; InstrD = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_obs", 32'(obs(0)), 32'h0);
    check("reset_busy", 32'(busy[0]), 32'h0);
    check("reset_last", 32'(last[0]), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // decode table on instance 0
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      InstrD = vecs[i].instr;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), 32'(obs(0)), 32'(vecs[i].exp));
      $display("vec %0d instr=%h obs=%h exp=%h", i, vecs[i].instr, obs(0), vecs[i].exp);
    end

    // flush in IDLE gives an all-zero E
    @(negedge clk);
    InstrD = I_ADD; FlushE = 1'b1;
    @(posedge clk);
    #1;
    check("flush_idle", 32'(obs(0)), 32'h0);
    $display("flush idle obs=%h", obs(0));

    // div on instance 0; flush is pulsed mid-sequence and must be ignored
    @(negedge clk);
    FlushE = 1'b0; InstrD = I_DIV;
    for (int k = 1; k <= 33; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("div_obs_k%0d", k), 32'(obs(0)), 32'(EXP_DIV));
      check($sformatf("div_busy_k%0d", k), 32'(busy[0]), 32'(k <= 32));
      check($sformatf("div_last_k%0d", k), 32'(last[0]), 32'(k == 33));
      check($sformatf("n1_busy_k%0d", k), 32'(busy[2]), 32'h0);
      if (k == 1) begin
        check("nom_div_illegal", 32'(ill[1]), 32'h1);
        check("nom_div_rw", 32'(rw[1]), 32'h0);
        check("n1_div_last", 32'(last[2]), 32'h1);
        check("n1_div_md", 32'(md[2]), 32'h1);
      end
      if (k == 4) check("n1_flush_idle", 32'(obs(2)), 32'h0);
      if (k == 3) FlushE = 1'b1;
      if (k == 5) FlushE = 1'b0;
      if (k == 33) InstrD = I_ADD;
      $display("div cycle %0d busy=%0b last=%0b md=%0b alu=%b", k, busy[0], last[0], md[0], alu[0]);
    end
    @(posedge clk);
    #1;
    check("after_div_md", 32'(md[0]), 32'h0);
    check("after_div_rw", 32'(rw[0]), 32'h1);
    check("after_div_alu", 32'(alu[0]), 32'h0);
    $display("after div obs=%h", obs(0));

    // mul (N=2) immediately followed by divu
    @(negedge clk);
    InstrD = I_MUL;
    @(posedge clk);
    #1;
    InstrD = I_DIVU;
    check("mul_c1_obs", 32'(obs(0)), 32'(EXP_MUL));
    check("mul_c1_busy", 32'(busy[0]), 32'h1);
    check("mul_c1_last", 32'(last[0]), 32'h0);
    $display("mul cycle 1 busy=%0b last=%0b", busy[0], last[0]);
    @(posedge clk);
    #1;
    check("mul_c2_obs", 32'(obs(0)), 32'(EXP_MUL));
    check("mul_c2_busy", 32'(busy[0]), 32'h0);
    check("mul_c2_last", 32'(last[0]), 32'h1);
    $display("mul cycle 2 busy=%0b last=%0b", busy[0], last[0]);
    @(posedge clk);
    #1;
    check("divu_c1_obs", 32'(obs(0)), 32'(EXP_DIVU));
    check("divu_c1_busy", 32'(busy[0]), 32'h1);
    check("divu_c1_last", 32'(last[0]), 32'h0);
    $display("divu cycle 1 busy=%0b alu=%b", busy[0], alu[0]);
    @(posedge clk);
    #1;
    check("divu_c2_busy", 32'(busy[0]), 32'h1);

    // reset mid-divu aborts the sequence
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_busy", 32'(busy[0]), 32'h0);
    check("rst_mid_md", 32'(md[0]), 32'h0);
    check("rst_mid_obs", 32'(obs(0)), 32'h0);
    $display("reset mid-divu busy=%0b md=%0b", busy[0], md[0]);
    @(negedge clk);
    rst = 1'b0; InstrD = I_AUIPC;
    #1;
    check("auipc_immsrc", 32'(imm[0]), 32'h4);
    @(posedge clk);
    #1;
    check("auipc_resultsrc", 32'(rsrc[0]), 32'h3);
    check("auipc_obs", 32'(obs(0)), 32'(vecs[19].exp));
    $display("auipc after reset obs=%h", obs(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
